// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the serial add/subtract engine.
// Optional overflow flag is enabled by defining SERIAL_ADDSUB_OVF_EN.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle for serial_addsub; overflow_o exists only when
// SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start_top_i;
  logic             mode_top_i;
  logic [WIDTH-1:0] a_top_i;
  logic [WIDTH-1:0] b_top_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH:0]   final_sum_o;

`ifdef SERIAL_ADDSUB_OVF_EN
  logic overflow_o;

  modport slave (
    input  start_top_i, mode_top_i, a_top_i, b_top_i,
    output ready_o, busy_o, done_o, final_sum_o, overflow_o
  );
  modport master (
    output start_top_i, mode_top_i, a_top_i, b_top_i,
    input  ready_o, busy_o, done_o, final_sum_o, overflow_o
  );
`else
  modport slave (
    input  start_top_i, mode_top_i, a_top_i, b_top_i,
    output ready_o, busy_o, done_o, final_sum_o
  );
  modport master (
    output start_top_i, mode_top_i, a_top_i, b_top_i,
    input  ready_o, busy_o, done_o, final_sum_o
  );
`endif

endinterface

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit ripple adder; c_msb is the carry into the top bit
// so the caller can derive signed overflow.
module serial_digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
  end

  assign cout  = carry[DIGIT];
  assign c_msb = carry[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor, LSB first, DIGIT bits per clock.
// Define SERIAL_ADDSUB_OVF_EN to add a registered signed-overflow flag.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clock_top_i,
  input  logic          reset_top_i,
  serial_addsub_if.slave bus
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg, sum_reg;
  logic               carry_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [WIDTH:0]     final_sum_reg;

  logic [DIGIT-1:0]   digit_sum;
  logic               digit_cout, digit_cmsb;
  logic [WIDTH-1:0]   sum_shifted;
  logic               accept, last_step, ready_c, busy_c, done_c;

  serial_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_reg[DIGIT-1:0]),
    .b     (b_reg[DIGIT-1:0]),
    .cin   (carry_reg),
    .sum   (digit_sum),
    .cout  (digit_cout),
    .c_msb (digit_cmsb)
  );

  // New digit enters at the MSB end so the first digit lands at bit 0.
  if (DIGIT == WIDTH) begin : g_whole
    assign sum_shifted = digit_sum;
  end else begin : g_part
    assign sum_shifted = {digit_sum, sum_reg[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clock_top_i or posedge reset_top_i) begin
    if (reset_top_i) state_reg <= IDLE;
    else             state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready_c    = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start_top_i) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (count_reg == CNT_W'(STEPS - 1)) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_top_i or posedge reset_top_i) begin
    if (reset_top_i) begin
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      count_reg     <= '0;
      final_sum_reg <= '0;
    end else if (accept) begin
      a_reg     <= bus.a_top_i;
      // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
      b_reg     <= (bus.mode_top_i == MODE_SUB) ? ~bus.b_top_i : bus.b_top_i;
      carry_reg <= bus.mode_top_i;
      count_reg <= '0;
      sum_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> DIGIT;
      b_reg     <= b_reg >> DIGIT;
      sum_reg   <= sum_shifted;
      carry_reg <= digit_cout;
      count_reg <= count_reg + CNT_W'(1);
      if (last_step) final_sum_reg <= {digit_cout, sum_shifted};
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clock_top_i or posedge reset_top_i) begin
    if (reset_top_i)                        ovf_reg <= 1'b0;
    else if (state_reg == RUN && last_step) ovf_reg <= digit_cmsb ^ digit_cout;
  end

  assign bus.overflow_o = ovf_reg;
`else
  logic ovf_unused;
  assign ovf_unused = digit_cmsb;
`endif

  // ready stays low while reset is held, even though the state is already IDLE.
  assign bus.ready_o     = ready_c & ~reset_top_i;
  assign bus.busy_o      = busy_c;
  assign bus.done_o      = done_c;
  assign bus.final_sum_o = final_sum_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized and directed bench for serial_addsub at DIGIT=1 and DIGIT=4.
// Define SERIAL_ADDSUB_OVF_EN to also check overflow_o.
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) if1 ();
  serial_addsub_if #(.WIDTH(8)) if4 ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clock_top_i (clk),
    .reset_top_i (rst),
    .bus         (if1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clock_top_i (clk),
    .reset_top_i (rst),
    .bus         (if4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; bit 8 is carry (add) or A>=B (sub).
  function automatic logic [8:0] model_sum(input logic mode, input logic [7:0] a, input logic [7:0] b);
    int ai = int'(a);
    int bi = int'(b);
    if (mode == MODE_ADD) return 9'(ai + bi);
    return {ai >= bi, 8'(ai - bi)};
  endfunction

  function automatic logic model_ovf(input logic mode, input logic [7:0] a, input logic [7:0] b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int r  = (mode == MODE_ADD) ? sa + sb : sa - sb;
    return (r > 127) || (r < -128);
  endfunction

  task automatic drive(input int sel, input logic s, input logic m, input logic [7:0] a, input logic [7:0] b);
    if (sel == 1) begin
      if1.start_top_i = s; if1.mode_top_i = m; if1.a_top_i = a; if1.b_top_i = b;
    end else begin
      if4.start_top_i = s; if4.mode_top_i = m; if4.a_top_i = a; if4.b_top_i = b;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 1) ? if1.ready_o : if4.ready_o;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 1) ? if1.busy_o : if4.busy_o;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 1) ? if1.done_o : if4.done_o;
  endfunction
  function automatic logic [8:0] get_sum(input int sel);
    return (sel == 1) ? if1.final_sum_o : if4.final_sum_o;
  endfunction
`ifdef SERIAL_ADDSUB_OVF_EN
  function automatic logic get_ovf(input int sel);
    return (sel == 1) ? if1.overflow_o : if4.overflow_o;
  endfunction
`endif

  // One full transaction on DUT "sel" (DIGIT value), checked against the model.
  task automatic run_op(input int sel, input logic mode, input logic [7:0] a, input logic [7:0] b, input string tag);
    int         steps = 8 / sel;
    int         n = 0;
    logic [8:0] exp = model_sum(mode, a, b);
    @(negedge clk);
    while (!get_ready(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_pre"}, 32'(get_ready(sel)), 1);
    drive(sel, 1'b1, mode, a, b);
    @(posedge clk);
    #1 drive(sel, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
    n = 1;
    @(negedge clk);
    check({tag, "_busy"}, 32'({get_busy(sel), get_ready(sel)}), 32'b10);
    while (!get_done(sel) && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_latency"}, n, steps + 1);
    check({tag, "_sum"}, 32'(get_sum(sel)), 32'(exp));
`ifdef SERIAL_ADDSUB_OVF_EN
    check({tag, "_ovf"}, 32'(get_ovf(sel)), 32'(model_ovf(mode, a, b)));
`endif
    $display("op %s digit=%0d mode=%0d a=%02h b=%02h sum=%03h exp=%03h edges=%0d",
             tag, sel, mode, a, b, get_sum(sel), exp, n);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'({get_done(sel), get_ready(sel)}), 32'b01);
  endtask

  initial begin
    int dones;
    int first_at;
    int second_at;
    int i;

    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("reset_outputs1", 32'({if1.ready_o, if1.busy_o, if1.done_o, if1.final_sum_o}), 0);
    check("reset_outputs4", 32'({if4.ready_o, if4.busy_o, if4.done_o, if4.final_sum_o}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'({if1.ready_o, if4.ready_o}), 32'b11);

    run_op(1, MODE_ADD, 8'd235, 8'd251, "add235_251");
    run_op(1, MODE_SUB, 8'd100, 8'd30,  "sub100_30");
    run_op(1, MODE_SUB, 8'd30,  8'd100, "sub30_100");
    run_op(4, MODE_ADD, 8'hFF,  8'hFF,  "d4_addFF");
    run_op(4, MODE_ADD, 8'h00,  8'h00,  "d4_add00");
    run_op(1, MODE_SUB, 8'h55,  8'h55,  "sub_equal");

    // Start while busy is ignored; a held start is re-accepted on the IDLE edge.
    @(negedge clk);
    drive(1, 1'b1, MODE_SUB, 8'd100, 8'd30);
    @(posedge clk);
    #1 drive(1, 1'b0, MODE_ADD, 8'hAA, 8'hBB);
    dones = 0; first_at = -1; second_at = -1;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) drive(1, 1'b1, MODE_ADD, 8'h11, 8'h22);
      if (get_done(1)) begin
        dones++;
        if (dones == 1) begin
          first_at = i;
          check("busy_start_first_sum", 32'(get_sum(1)), 32'h146);
        end else if (dones == 2) begin
          second_at = i;
          check("busy_start_second_sum", 32'(get_sum(1)), 32'h033);
        end
      end
      if (dones >= 1 && get_busy(1)) drive(1, 1'b0, MODE_ADD, 8'h00, 8'h00);
    end
    check("busy_start_done_count", dones, 2);
    check("busy_start_first_at", first_at, 8);
    check("busy_start_second_at", second_at, 18);
    $display("op busy_start dones=%0d first=%0d second=%0d", dones, first_at, second_at);

    // Abort mid-run at step 4 of 8.
    @(negedge clk);
    drive(1, 1'b1, MODE_ADD, 8'hF0, 8'h0F);
    @(posedge clk);
    #1 drive(1, 1'b0, MODE_ADD, 8'h00, 8'h00);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("abort_outputs", 32'({if1.ready_o, if1.busy_o, if1.done_o, if1.final_sum_o}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (i = 0; i < 14; i++) begin
      @(negedge clk);
      if (get_done(1)) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_sum_cleared", 32'(get_sum(1)), 0);
    $display("op abort dones=%0d", dones);
    run_op(1, MODE_ADD, 8'h20, 8'h30, "after_abort");

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    drive(1, 1'b1, MODE_ADD, 8'h01, 8'h02);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1'b0, MODE_ADD, 8'h00, 8'h00);
    @(negedge clk);
    check("reset_beats_start", 32'({get_busy(1), get_ready(1)}), 32'b01);
    $display("op reset_vs_start busy=%0d", get_busy(1));

`ifdef SERIAL_ADDSUB_OVF_EN
    run_op(1, MODE_ADD, 8'h7F, 8'h01, "ovf_add7F");
    run_op(1, MODE_SUB, 8'h80, 8'h01, "ovf_sub80");
    run_op(4, MODE_ADD, 8'h10, 8'h10, "ovf_add10");
    run_op(4, MODE_SUB, 8'h80, 8'h01, "d4_ovf_sub80");
`endif

    for (int k = 0; k < 30; k++) begin
      run_op(($urandom % 2) ? 1 : 4, 1'($urandom), 8'($urandom), 8'($urandom), $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
